axil_reg_slave: RTL and testbench
=================================

// Module: axil_reg_slave
// PURPOSE
// - AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
// - Mapped at base 0x44A0_0000 by the system interconnect; reg i sits at byte offset 4*i.
// - Sits behind the block-design AXI master (VIP in simulation, CPU in hardware) in design_1.
// - Data written to a register reads back unchanged.
// PARAMETERS
// - ADDR_W    4   byte-address bits decoded (offset within the slave window)
// - NUM_REGS  4   number of 32-bit registers; must be <= 2**(ADDR_W-2)
// PORTS
// - aclk     in  1       single clock; all logic is rising-edge
// - areset   in  1       reset, synchronous, active-high
// - awaddr   in  ADDR_W  write address; awprot in 3 (ignored)
// - awvalid  in 1; awready out 1
// - wdata    in 32; wstrb in 4; wvalid in 1; wready out 1
// - bresp    out 2; bvalid out 1; bready in 1
// - araddr   in ADDR_W; arprot in 3 (ignored); arvalid in 1; arready out 1
// - rdata    out 32; rresp out 2; rvalid out 1; rready in 1
// BEHAVIOUR
// - Reset:
//   - all regs = 0; awready/wready/arready = 0; bvalid/rvalid = 0; rdata = 0; bresp/rresp = OKAY.
//   - Reset mid-transaction abandons it; no write is committed after reset asserts.
// - Decode: word index = addr[ADDR_W-1:2]; addr[1:0] ignored.
// - Write channel: AW and W accepted independently, in either order or the same cycle.
//   - awready=1 while no AW is latched and no B is pending; wready likewise for W.
//   - Each ready drops for the cycle after its handshake.
//   - Once both AW and W are latched, the write commits next edge:
//     byte lane k updated iff wstrb[k].
//   - bvalid rises in the same cycle as the commit; bresp and bvalid are held until bready.
//   - After the B handshake, awready/wready re-assert the following cycle.
//   - Latency: AW+W same cycle -> bvalid 1 cycle later. One write outstanding max.
// - Read channel: arready=1 while rvalid=0.
//   - On AR handshake, rdata/rresp are registered; rvalid=1 next cycle.
//   - rdata/rresp/rvalid are held stable until rready; arready re-asserts after the R handshake.
// - Reads and writes are independent and may overlap.
// - Read of a register written in the same commit cycle returns the old value.
// - Index >= NUM_REGS:
//   - writes are dropped; reads return 0x0000_0000;
//   - response per CONFIGURATION.
// - All outputs are registered; no combinational valid->ready paths.
// CONFIGURATION
// - AXIL_SLVERR_EN defined: out-of-range access returns SLVERR (2'b10) on bresp/rresp.
// - Not defined: every access returns OKAY (2'b00); drop/zero rules unchanged.
// STRUCTURE
// - Package axil_pkg:
//   - typedef logic [1:0] axil_resp_t;
//   - constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10;
//   - DATA_W=32, STRB_W=4.
// - Sub-module axil_regfile holds storage:
//   - write port: we, windex, wdata, wstrb;
//   - async read port: rindex -> rdata;
//   - flags index >= NUM_REGS.
// - Top implements the handshake/FSM logic:
//   - write FSM: IDLE -> (AW|W latched) PARTIAL -> COMMIT -> RESP -> IDLE;
//   - read FSM: IDLE -> DATA -> IDLE.
// TESTING
// - Write 0x0123_4567 @0x0 and 0x89AB_CDEF @0x4; read both back
//   -> rdata 0x0123_4567 / 0x89AB_CDEF, OKAY.
// - Write ordering:
//   - W presented 3 cycles before AW @0x8 data 0xDEAD_BEEF -> single commit, one bvalid;
//   - read @0x8 -> 0xDEAD_BEEF.
// - Strobes: reg0=0xFFFF_FFFF, then write 0x0000_0000 with wstrb=4'b0101 -> read 0xFF00_FF00.
// - Backpressure:
//   - bready/rready held low 5 cycles -> bvalid/rvalid and data stay stable;
//   - awready/arready stay 0 until handshake.
// - Out-of-range: write 0x1234 @0x10 then read @0x10 -> rdata 0; regs 0..3 unchanged;
//   - resp SLVERR with AXIL_SLVERR_EN, OKAY without.
// - Reset: assert areset while bvalid=1 -> next cycle bvalid=0, all regs read 0 after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
package axil_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PARTIAL,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R channels) with master and slave views.
interface axil_if #(
  parameter int unsigned ADDR_W = 4
);
  import axil_pkg::*;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;

  axil_resp_t        bresp;
  logic              bvalid;
  logic              bready;

  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;

  logic [DATA_W-1:0] rdata;
  axil_resp_t        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axil_regfile.sv
// Register storage: byte-strobed synchronous write port, asynchronous read
// port, and out-of-range flags for both indices.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-3:0]    windex,
  input  logic [DATA_W-1:0]    wdata,
  input  logic [STRB_W-1:0]    wstrb,
  input  logic [ADDR_W-3:0]    rindex,
  output logic [DATA_W-1:0]    rdata,
  output logic                 w_oor,
  output logic                 r_oor
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign w_oor = 32'(windex) >= NUM_REGS;
  assign r_oor = 32'(rindex) >= NUM_REGS;

  // Storage update: clear on reset, otherwise strobed byte-lane writes to in-range indices.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && !w_oor) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (windex == IDX_W'(i)) begin
          for (int unsigned k = 0; k < STRB_W; k++) begin
            if (wstrb[k]) regs[i][8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end
    end
  end

  // Read mux: out-of-range indices match no register and read as zero.
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rindex == IDX_W'(i)) rdata = regs[i];
    end
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with NUM_REGS 32-bit registers at byte offset 4*i.
// Optional macro AXIL_SLVERR_EN: out-of-range accesses answer SLVERR
// instead of OKAY.
module axil_reg_slave
  import axil_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 4
) (
  input logic  aclk,
  input logic  areset,
  axil_if.slave bus
);

  localparam int unsigned IDX_W = ADDR_W - 2;

`ifdef AXIL_SLVERR_EN
  localparam axil_resp_t OOR_RESP = RESP_SLVERR;
`else
  localparam axil_resp_t OOR_RESP = RESP_OKAY;
`endif

  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;

  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              aw_have_q, aw_have_d;
  logic              w_have_q, w_have_d;
  logic              bvalid_q, bvalid_d;
  axil_resp_t        bresp_q, bresp_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  axil_resp_t        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [IDX_W-1:0]  awidx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic              rf_we;
  logic [DATA_W-1:0] rf_rdata;
  logic              w_oor, r_oor;

  logic aw_hs, w_hs, ar_hs;
  assign aw_hs = bus.awvalid && awready_q;
  assign w_hs  = bus.wvalid && wready_q;
  assign ar_hs = bus.arvalid && arready_q;

  logic unused_bits;
  assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[1:0], bus.araddr[1:0]};

  axil_regfile #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk    (aclk),
    .rst    (areset),
    .we     (rf_we),
    .windex (awidx_q),
    .wdata  (wdata_q),
    .wstrb  (wstrb_q),
    .rindex (bus.araddr[ADDR_W-1:2]),
    .rdata  (rf_rdata),
    .w_oor  (w_oor),
    .r_oor  (r_oor)
  );

  // Write FSM: collect AW and W in any order, commit for one cycle, hold B until accepted.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_have_d  = aw_have_q;
    w_have_d   = w_have_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    rf_we      = 1'b0;
    unique case (wr_state_q)
      WR_IDLE, WR_PARTIAL: begin
        aw_have_d = aw_have_q || aw_hs;
        w_have_d  = w_have_q || w_hs;
        awready_d = !aw_have_d;
        wready_d  = !w_have_d;
        if (aw_have_d && w_have_d)      wr_state_d = WR_COMMIT;
        else if (aw_have_d || w_have_d) wr_state_d = WR_PARTIAL;
      end
      WR_COMMIT: begin
        rf_we      = 1'b1;
        bvalid_d   = 1'b1;
        bresp_d    = w_oor ? OOR_RESP : RESP_OKAY;
        aw_have_d  = 1'b0;
        w_have_d   = 1'b0;
        wr_state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bus.bready) begin
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = WR_IDLE;
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Read FSM: capture data on AR handshake, hold R until accepted.
  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = rf_rdata;
          rresp_d    = r_oor ? OOR_RESP : RESP_OKAY;
          rd_state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (bus.rready) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // State and registered handshake outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_have_q  <= 1'b0;
      w_have_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_have_q  <= aw_have_d;
      w_have_q   <= w_have_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Latch write address and data at their handshakes.
  always_ff @(posedge aclk) begin
    if (areset) begin
      awidx_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      if (aw_hs) awidx_q <= bus.awaddr[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed cases plus randomized
// traffic against an array-based register model.
module tb_axil_reg_slave;
  import axil_pkg::*;

  localparam int unsigned AW = 5;
  localparam int unsigned NR = 4;

`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] OOR_EXP = 2'b10;
`else
  localparam logic [1:0] OOR_EXP = 2'b00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] model [8];

  axil_if #(.ADDR_W(AW)) bus ();

  axil_reg_slave #(
    .ADDR_W   (AW),
    .NUM_REGS (NR)
  ) dut (
    .aclk   (clk),
    .areset (rst),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_resp(input int unsigned idx);
    return (idx >= NR) ? OOR_EXP : 2'b00;
  endfunction

  function automatic logic [31:0] model_read(input int unsigned idx);
    return (idx < NR) ? model[idx] : 32'h0;
  endfunction

  task automatic model_write(input int unsigned idx, input logic [31:0] d, input logic [3:0] s);
    if (idx < NR) begin
      for (int k = 0; k < 4; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
    end
  endtask

  // lead > 0: W precedes AW by lead cycles; lead < 0: AW precedes W.
  task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int lead, input int bhold);
    int aw_start, w_start, cyc, n;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [1:0] r;
    int unsigned idx;
    idx = 32'(addr[AW-1:2]);
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    bus.awaddr = addr;
    bus.awprot = 3'($urandom);
    bus.wdata  = data;
    bus.wstrb  = strb;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      bus.awvalid = !aw_done && cyc >= aw_start;
      bus.wvalid  = !w_done && cyc >= w_start;
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      tick();
      if (aw_fire) begin aw_done = 1; check("awready_drop", 32'(bus.awready), 0); end
      if (w_fire)  begin w_done = 1;  check("wready_drop", 32'(bus.wready), 0); end
      cyc++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("aw_w_accept", {30'h0, aw_done, w_done}, 32'h3);
    n = 0;
    while (!bus.bvalid && n < 20) begin
      check("ready_low_before_b", {30'h0, bus.awready, bus.wready}, 0);
      tick();
      n++;
    end
    check("b_latency", n, 1);
    model_write(idx, data, strb);
    check("bresp", 32'(bus.bresp), 32'(exp_resp(idx)));
    r = bus.bresp;
    repeat (bhold) begin
      tick();
      check("bvalid_hold", 32'(bus.bvalid), 1);
      check("bresp_hold", 32'(bus.bresp), 32'(r));
      check("ready_low_hold", {30'h0, bus.awready, bus.wready}, 0);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("bvalid_clear", 32'(bus.bvalid), 0);
    check("ready_reassert", {30'h0, bus.awready, bus.wready}, 32'h3);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, input int rhold, input string tag);
    int n;
    logic [31:0] d;
    logic [1:0] r;
    int unsigned idx;
    idx = 32'(addr[AW-1:2]);
    bus.araddr  = addr;
    bus.arprot  = 3'($urandom);
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin tick(); n++; end
    check({tag, "_arready"}, 32'(bus.arready), 1);
    tick();
    bus.arvalid = 1'b0;
    check({tag, "_rvalid"}, 32'(bus.rvalid), 1);
    check({tag, "_rdata"}, bus.rdata, model_read(idx));
    check({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_resp(idx)));
    d = bus.rdata;
    r = bus.rresp;
    repeat (rhold) begin
      tick();
      check({tag, "_rvalid_hold"}, 32'(bus.rvalid), 1);
      check({tag, "_rdata_hold"}, bus.rdata, d);
      check({tag, "_rresp_hold"}, 32'(bus.rresp), 32'(r));
      check({tag, "_arready_low"}, 32'(bus.arready), 0);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check({tag, "_rvalid_clear"}, 32'(bus.rvalid), 0);
    check({tag, "_arready_back"}, 32'(bus.arready), 1);
  endtask

  initial begin
    int n;
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;

    repeat (3) tick();
    check("rst_awready", 32'(bus.awready), 0);
    check("rst_wready", 32'(bus.wready), 0);
    check("rst_arready", 32'(bus.arready), 0);
    check("rst_bvalid", 32'(bus.bvalid), 0);
    check("rst_rvalid", 32'(bus.rvalid), 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_resp", {28'h0, bus.bresp, bus.rresp}, 0);
    rst = 1'b0;
    tick();
    tick();

    axi_write(5'h00, 32'h0123_4567, 4'hF, 0, 0);
    axi_write(5'h04, 32'h89AB_CDEF, 4'hF, 0, 0);
    axi_read(5'h00, 0, "basic0");
    axi_read(5'h04, 0, "basic1");

    axi_write(5'h08, 32'hDEAD_BEEF, 4'hF, 3, 0);
    axi_read(5'h08, 0, "w_first");
    axi_write(5'h0C, 32'hCAFE_F00D, 4'hF, -2, 0);
    axi_read(5'h0C, 0, "aw_first");

    axi_write(5'h00, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_write(5'h00, 32'h0000_0000, 4'b0101, 0, 0);
    axi_read(5'h00, 0, "strobe");

    axi_write(5'h04, 32'h5A5A_A5A5, 4'hF, 0, 5);
    axi_read(5'h04, 5, "bp");

    axi_write(5'h10, 32'h0000_1234, 4'hF, 0, 0);
    axi_read(5'h10, 0, "oor");
    for (int i = 0; i < 4; i++) axi_read(AW'(4 * i), 0, "oor_keep");

    for (int i = 0; i < 40; i++) begin
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) a[AW-1] = 1'b0;
      axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 6) - 3, $urandom_range(0, 2));
      a = AW'($urandom_range(0, 31));
      axi_read(a, $urandom_range(0, 2), "rand");
    end

    bus.awaddr = 5'h04;
    bus.wdata = $urandom;
    bus.wstrb = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin tick(); n++; end
    check("mid_bvalid_seen", 32'(bus.bvalid), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_bvalid", 32'(bus.bvalid), 0);
    check("mid_rst_awready", 32'(bus.awready), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    tick();
    for (int i = 0; i < 4; i++) axi_read(AW'(4 * i), 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
